// File: rtl/qed_dup_scheduler.sv
// qed_dup_scheduler: sequences one SQED run around the qed instruction transformer.
//
// Phases: ORIG issues originals with exec_dup low. DUP raises exec_dup and issues the
// matching duplicates. DRAIN waits for the core to retire everything. CHECK raises
// qed_ready so the register-equality properties can be evaluated.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   exec_dup_req          request to leave ORIG early (free formal input)
//   qed_vld_out, stall_IF issue handshake; an issue is qed_vld_out & ~stall_IF
//   arfwe1/2, dstarf1/2   two architectural commit ports (enable + destination)
//   exec_dup              registered duplicate-mode select driven back into qed
//   qed_ready             sticky: commit counts of both halves matched
//   drain_timeout         sticky: no counted commit for DRAIN_MAX cycles in DRAIN
//   state                 ORIG=0, DUP=1, DRAIN=2, CHECK=3
//   orig_issued, dup_issued, orig_commit, dup_commit   saturating event counters
module qed_dup_scheduler #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_ORIG  = 16,
  parameter int unsigned DRAIN_MAX = 64,
  parameter int unsigned REG_SEL   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exec_dup_req,
  input  logic               qed_vld_out,
  input  logic               stall_IF,
  input  logic               arfwe1,
  input  logic               arfwe2,
  input  logic [REG_SEL-1:0] dstarf1,
  input  logic [REG_SEL-1:0] dstarf2,
  output logic               exec_dup,
  output logic               qed_ready,
  output logic               drain_timeout,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   orig_issued,
  output logic [CNT_W-1:0]   dup_issued,
  output logic [CNT_W-1:0]   orig_commit,
  output logic [CNT_W-1:0]   dup_commit
);

  localparam int unsigned DrW = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] MaxOrig  = CNT_W'(MAX_ORIG);
  localparam logic [DrW-1:0]   DrainMax = DrW'(DRAIN_MAX);

  typedef enum logic [1:0] {
    StOrig  = 2'd0,
    StDup   = 2'd1,
    StDrain = 2'd2,
    StCheck = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             exec_dup_q, exec_dup_d;
  logic             qed_ready_q, qed_ready_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic [CNT_W-1:0] orig_issued_q, orig_issued_d;
  logic [CNT_W-1:0] dup_issued_q, dup_issued_d;
  logic [CNT_W-1:0] orig_commit_q, orig_commit_d;
  logic [CNT_W-1:0] dup_commit_q, dup_commit_d;
  logic [DrW-1:0]   drain_cnt_q, drain_cnt_d;

  logic       issue;
  logic [1:0] orig_inc, dup_inc;
  logic       commit_any;

  // Original half is r1..r15, duplicate half r17..r31; r0 and r16 never count.
  function automatic logic is_orig_reg(logic [REG_SEL-1:0] d);
    return (d >= REG_SEL'(1)) && (d <= REG_SEL'(15));
  endfunction

  function automatic logic is_dup_reg(logic [REG_SEL-1:0] d);
    return (d >= REG_SEL'(17)) && (d <= REG_SEL'(31));
  endfunction

  // Add 0..2 without wrapping; the extra carry bit flags overflow.
  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign issue      = qed_vld_out & ~stall_IF;
  assign orig_inc   = {1'b0, arfwe1 & is_orig_reg(dstarf1)} + {1'b0, arfwe2 & is_orig_reg(dstarf2)};
  assign dup_inc    = {1'b0, arfwe1 & is_dup_reg(dstarf1)} + {1'b0, arfwe2 & is_dup_reg(dstarf2)};
  assign commit_any = (orig_inc != 2'd0) | (dup_inc != 2'd0);

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StOrig;
      exec_dup_q      <= 1'b0;
      qed_ready_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
      orig_issued_q   <= '0;
      dup_issued_q    <= '0;
      orig_commit_q   <= '0;
      dup_commit_q    <= '0;
      drain_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      exec_dup_q      <= exec_dup_d;
      qed_ready_q     <= qed_ready_d;
      drain_timeout_q <= drain_timeout_d;
      orig_issued_q   <= orig_issued_d;
      dup_issued_q    <= dup_issued_d;
      orig_commit_q   <= orig_commit_d;
      dup_commit_q    <= dup_commit_d;
      drain_cnt_q     <= drain_cnt_d;
    end
  end

  // Counter next-values ("_nxt" values include this cycle's events).
  always_comb begin
    orig_issued_d = orig_issued_q;
    dup_issued_d  = dup_issued_q;
    orig_commit_d = orig_commit_q;
    dup_commit_d  = dup_commit_q;
    drain_cnt_d   = drain_cnt_q;

    // Issues are attributed by the registered mode; none count past DUP.
    if (state_q == StOrig && issue && orig_issued_q != MaxOrig) begin
      orig_issued_d = sat_add(orig_issued_q, 2'd1);
    end
    if (state_q == StDup && issue) begin
      dup_issued_d = sat_add(dup_issued_q, 2'd1);
    end

    if (state_q != StCheck) begin
      orig_commit_d = sat_add(orig_commit_q, orig_inc);
      dup_commit_d  = sat_add(dup_commit_q, dup_inc);
    end

    if (state_q == StDrain) begin
      if (commit_any) begin
        drain_cnt_d = '0;
      end else if (drain_cnt_q != DrainMax) begin
        drain_cnt_d = drain_cnt_q + DrW'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOrig: begin
        // Only switch on an unstalled cycle so a held instruction keeps its mode.
        if (!stall_IF && orig_issued_d != '0 &&
            (exec_dup_req || orig_issued_d == MaxOrig)) begin
          state_d = StDup;
        end
      end
      StDup: begin
        if (dup_issued_d == orig_issued_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // In-order commit means equal nonzero counts imply both halves retired.
        if (!drain_timeout_q && dup_commit_d == orig_commit_d && dup_commit_d != '0) begin
          state_d = StCheck;
        end
      end
      StCheck: state_d = StCheck;
      default: state_d = StOrig;
    endcase
  end

  // Registered outputs.
  always_comb begin
    exec_dup_d      = (state_d != StOrig);
    qed_ready_d     = qed_ready_q | (state_q == StCheck);
    drain_timeout_d = drain_timeout_q | ((state_q == StDrain) && (drain_cnt_d == DrainMax));
  end

  assign exec_dup      = exec_dup_q;
  assign qed_ready     = qed_ready_q;
  assign drain_timeout = drain_timeout_q;
  assign state         = state_q;
  assign orig_issued   = orig_issued_q;
  assign dup_issued    = dup_issued_q;
  assign orig_commit   = orig_commit_q;
  assign dup_commit    = dup_commit_q;

endmodule

// File: tb/tb_qed_dup_scheduler.sv
// Bench for qed_dup_scheduler: a default-size instance and a small one (CNT_W=2) share
// stimulus; each is compared every cycle against its own behavioural model.
module tb_qed_dup_scheduler;

  localparam int MCW = 8, MMO = 16, MDM = 64;
  localparam int SCW = 2, SMO = 3,  SDM = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0, vld = 1'b0, stall = 1'b0, we1 = 1'b0, we2 = 1'b0;
  logic [4:0] d1 = '0, d2 = '0;

  logic           m_ed, m_rdy, m_tmo;
  logic [1:0]     m_st;
  logic [MCW-1:0] m_oi, m_di, m_oc, m_dc;
  logic           s_ed, s_rdy, s_tmo;
  logic [1:0]     s_st;
  logic [SCW-1:0] s_oi, s_di, s_oc, s_dc;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  qed_dup_scheduler #(.CNT_W(MCW), .MAX_ORIG(MMO), .DRAIN_MAX(MDM), .REG_SEL(5)) u_main (
    .clk(clk), .rst_n(rst_n), .exec_dup_req(req), .qed_vld_out(vld), .stall_IF(stall),
    .arfwe1(we1), .arfwe2(we2), .dstarf1(d1), .dstarf2(d2),
    .exec_dup(m_ed), .qed_ready(m_rdy), .drain_timeout(m_tmo), .state(m_st),
    .orig_issued(m_oi), .dup_issued(m_di), .orig_commit(m_oc), .dup_commit(m_dc)
  );

  qed_dup_scheduler #(.CNT_W(SCW), .MAX_ORIG(SMO), .DRAIN_MAX(SDM), .REG_SEL(5)) u_small (
    .clk(clk), .rst_n(rst_n), .exec_dup_req(req), .qed_vld_out(vld), .stall_IF(stall),
    .arfwe1(we1), .arfwe2(we2), .dstarf1(d1), .dstarf2(d2),
    .exec_dup(s_ed), .qed_ready(s_rdy), .drain_timeout(s_tmo), .state(s_st),
    .orig_issued(s_oi), .dup_issued(s_di), .orig_commit(s_oc), .dup_commit(s_dc)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int st; int ed; int rdy; int tmo; int oi; int di; int oc; int dc; int dr;
  } mdl_t;

  localparam mdl_t Zero = '{st: 0, ed: 0, rdy: 0, tmo: 0, oi: 0, di: 0, oc: 0, dc: 0, dr: 0};

  mdl_t mm = Zero;
  mdl_t sm = Zero;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int half_o(bit w, int d);
    return (w && d >= 1 && d <= 15) ? 1 : 0;
  endfunction

  function automatic int half_d(bit w, int d);
    return (w && d >= 17 && d <= 31) ? 1 : 0;
  endfunction

  function automatic mdl_t step(mdl_t s, int cw, int maxo, int dmax, bit r, bit v, bit stl,
                                bit w1, int a1, bit w2, int a2);
    mdl_t n;
    int   cmax, oinc, dinc;
    bit   iss;
    n    = s;
    cmax = (1 << cw) - 1;
    iss  = v && !stl;
    oinc = half_o(w1, a1) + half_o(w2, a2);
    dinc = half_d(w1, a1) + half_d(w2, a2);
    if (s.st != 3) begin
      n.oc = imin(s.oc + oinc, cmax);
      n.dc = imin(s.dc + dinc, cmax);
    end
    case (s.st)
      0: begin
        if (iss && s.oi < maxo) n.oi = s.oi + 1;
        if (!stl && n.oi != 0 && (r || n.oi == maxo)) n.st = 1;
      end
      1: begin
        if (iss) n.di = imin(s.di + 1, cmax);
        if (n.di == s.oi) n.st = 2;
      end
      2: begin
        n.dr = (oinc + dinc > 0) ? 0 : imin(s.dr + 1, dmax);
        if (s.tmo == 0 && n.dc == n.oc && n.dc != 0) n.st = 3;
        if (n.dr == dmax) n.tmo = 1;
      end
      default: n.rdy = 1;
    endcase
    n.ed = (n.st != 0) ? 1 : 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm <= Zero;
      sm <= Zero;
    end else begin
      mm <= step(mm, MCW, MMO, MDM, req, vld, stall, we1, int'(d1), we2, int'(d2));
      sm <= step(sm, SCW, SMO, SDM, req, vld, stall, we1, int'(d1), we2, int'(d2));
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_state", int'(m_st), mm.st);
      check("m_exec_dup", int'(m_ed), mm.ed);
      check("m_qed_ready", int'(m_rdy), mm.rdy);
      check("m_drain_timeout", int'(m_tmo), mm.tmo);
      check("m_orig_issued", int'(m_oi), mm.oi);
      check("m_dup_issued", int'(m_di), mm.di);
      check("m_orig_commit", int'(m_oc), mm.oc);
      check("m_dup_commit", int'(m_dc), mm.dc);
      check("s_state", int'(s_st), sm.st);
      check("s_exec_dup", int'(s_ed), sm.ed);
      check("s_qed_ready", int'(s_rdy), sm.rdy);
      check("s_drain_timeout", int'(s_tmo), sm.tmo);
      check("s_orig_issued", int'(s_oi), sm.oi);
      check("s_dup_issued", int'(s_di), sm.di);
      check("s_orig_commit", int'(s_oc), sm.oc);
      check("s_dup_commit", int'(s_dc), sm.dc);
    end
  end

  // ---------------- stimulus ----------------
  // Apply one cycle of inputs, then return at the following negedge + 2.
  task automatic drive(input bit v, input bit stl, input bit r,
                       input bit w1, input int a1, input bit w2, input int a2);
    vld = v; stall = stl; req = r;
    we1 = w1; d1 = 5'(a1); we2 = w2; d2 = 5'(a2);
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    vld = 0; stall = 0; req = 0; we1 = 0; we2 = 0; d1 = '0; d2 = '0;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("reset_state", int'(m_st), 0);
    check("reset_exec_dup", int'(m_ed), 0);
    check("reset_orig_issued", int'(m_oi), 0);

    // Three originals, request on the third; then three duplicates.
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    check("sw_exec_dup", int'(m_ed), 1);
    check("sw_orig_issued", int'(m_oi), 3);
    check("sw_state", int'(m_st), 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
    check("dup_done_state", int'(m_st), 2);
    check("dup_done_count", int'(m_di), 3);

    // Commits: r1, r2, r3, then r0/r16 (ignored), r17+r18 together, then r19.
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 0);
    drive(0, 0, 0, 1, 3, 0, 0);
    check("oc_three", int'(m_oc), 3);
    drive(0, 0, 0, 1, 0, 1, 16);
    check("r0_r16_oc", int'(m_oc), 3);
    check("r0_r16_dc", int'(m_dc), 0);
    drive(0, 0, 0, 1, 17, 1, 18);
    check("dual_dc", int'(m_dc), 2);
    check("dual_state", int'(m_st), 2);
    drive(0, 0, 0, 1, 19, 0, 0);
    check("match_dc", int'(m_dc), 3);
    check("match_state", int'(m_st), 3);
    check("match_ready_lag", int'(m_rdy), 0);
    idle(1);
    check("ready_set", int'(m_rdy), 1);
    drive(0, 0, 0, 1, 1, 1, 17);
    check("frozen_oc", int'(m_oc), 3);
    check("frozen_dc", int'(m_dc), 3);

    // Asynchronous reset in the middle of DUP.
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("middup_di", int'(m_di), 1);
    rst_n = 1'b0;
    #1;
    check("async_state", int'(m_st), 0);
    check("async_exec_dup", int'(m_ed), 0);
    check("async_oi", int'(m_oi), 0);
    check("async_di", int'(m_di), 0);
    check("async_ready", int'(m_rdy), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // No request: forced switch at MAX_ORIG, stalls interleaved.
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
    end
    check("forced_oi15", int'(m_oi), 15);
    check("forced_state15", int'(m_st), 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    check("stall_hold_state", int'(m_st), 0);
    check("stall_hold_ed", int'(m_ed), 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("forced_state", int'(m_st), 1);
    check("forced_oi16", int'(m_oi), 16);
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 0, 0, 0, 0);
    check("forced_drain", int'(m_st), 2);

    // Drain watchdog: two originals commit, duplicates never do.
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 0);
    idle(63);
    check("tmo_before", int'(m_tmo), 0);
    idle(1);
    check("tmo_set", int'(m_tmo), 1);
    check("tmo_state", int'(m_st), 2);
    check("tmo_ready", int'(m_rdy), 0);

    // Saturation on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 1, 0, 0);
    check("sat_small_oc", int'(s_oc), 3);
    check("sat_main_oc", int'(m_oc), 5);
    drive(0, 0, 0, 1, 3, 1, 5);
    check("sat_small_oc2", int'(s_oc), 3);
    check("sat_main_oc2", int'(m_oc), 7);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) < 4), int'($urandom_range(0, 31)),
              ($urandom_range(0, 9) < 4), int'($urandom_range(0, 31)));
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
